// File: rtl/plot_pkg.sv
// plot_pkg: definitions shared by the VGA plot arbiter and its helpers.
//   state_t       : arbiter FSM states
//   X_W/Y_W/COL_W : screen coordinate and colour widths
//   SPRITE_PIXELS : pixel count of one 20x20 sprite draw
package plot_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int X_W           = 9;
  localparam int Y_W           = 8;
  localparam int COL_W         = 3;
  localparam int SPRITE_PIXELS = 400;

endpackage

// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if: bundle between the sprite FSMs and the plot arbiter.
//   Client side : req, done, plot_in, x_in, y_in, colour_in (packed per client)
//   Arbiter side: grant, x_out, y_out, colour_out, plot_out, busy, timeout
//   modport master : sprite FSMs / VGA adapter view
//   modport slave  : arbiter view
interface plot_arbiter_if #(
  parameter int N_CLIENTS = 3
);
  import plot_pkg::*;

  logic [N_CLIENTS-1:0]       req;
  logic [N_CLIENTS-1:0]       done;
  logic [N_CLIENTS-1:0]       plot_in;
  logic [X_W*N_CLIENTS-1:0]   x_in;
  logic [Y_W*N_CLIENTS-1:0]   y_in;
  logic [COL_W*N_CLIENTS-1:0] colour_in;

  logic [N_CLIENTS-1:0]       grant;
  logic [X_W-1:0]             x_out;
  logic [Y_W-1:0]             y_out;
  logic [COL_W-1:0]           colour_out;
  logic                       plot_out;
  logic                       busy;
  logic                       timeout;

  modport master (
    output req, done, plot_in, x_in, y_in, colour_in,
    input  grant, x_out, y_out, colour_out, plot_out, busy, timeout
  );

  modport slave (
    input  req, done, plot_in, x_in, y_in, colour_in,
    output grant, x_out, y_out, colour_out, plot_out, busy, timeout
  );

endinterface

// File: rtl/plot_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   req    in  N   request vector
//   rr_ptr in  IW  index with highest priority this round
//   pick   out N   one-hot winner (zero when no request)
//   valid  out 1   at least one request present
// Scans rr_ptr, rr_ptr+1, ... modulo N and picks the first set request.
module rr_select #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [IW-1:0] j;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(rr_ptr) + k) % N);
      if (!valid && req[j]) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single VGA plot port between N sprite FSMs.
//   clk    in  system clock
//   resetn in  synchronous reset, active-high despite the name
//   hold   in  blocks new grants (screen erase); current grant runs on
//   bus    slave modport of plot_arbiter_if:
//            req/done/plot_in/x_in/y_in/colour_in from clients,
//            grant/x_out/y_out/colour_out/plot_out/busy/timeout out.
// A grant lasts one full sprite draw and ends on done[idx] or when the
// watchdog reaches MAX_GRANT cycles; every grant is followed by a gap cycle.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int N_CLIENTS = 3,
  parameter int MAX_GRANT = 1023,
  parameter int CW        = 10
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           hold,
  plot_arbiter_if.slave  bus
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  state_t               state_q, state_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        wdog_q, wdog_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [X_W-1:0]       x_out_q, x_out_d;
  logic [Y_W-1:0]       y_out_q, y_out_d;
  logic [COL_W-1:0]     colour_out_q, colour_out_d;
  logic                 plot_out_q, plot_out_d;

  logic [N_CLIENTS-1:0] sel_pick;
  logic                 sel_valid;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        rr_next;

  logic [X_W-1:0]       x_sel;
  logic [Y_W-1:0]       y_sel;
  logic [COL_W-1:0]     colour_sel;
  logic                 plot_sel;

  rr_select #(
    .N  (N_CLIENTS),
    .IW (IW)
  ) u_rr_select (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (sel_pick),
    .valid  (sel_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (sel_pick[k]) sel_idx = IW'(k);
    end
  end

  assign rr_next = (idx_q == IW'(N_CLIENTS - 1)) ? '0 : idx_q + 1'b1;

  // Slice of the currently latched client.
  always_comb begin
    x_sel      = '0;
    y_sel      = '0;
    colour_sel = '0;
    plot_sel   = 1'b0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (idx_q == IW'(k)) begin
        x_sel      = bus.x_in[X_W*k +: X_W];
        y_sel      = bus.y_in[Y_W*k +: Y_W];
        colour_sel = bus.colour_in[COL_W*k +: COL_W];
        plot_sel   = bus.plot_in[k] & grant_q[k];
      end
    end
  end

  // FSM next state, grant and watchdog.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    wdog_d    = wdog_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!hold && sel_valid) begin
          idx_d   = sel_idx;
          grant_d = sel_pick;
          busy_d  = 1'b1;
          wdog_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // done takes priority over the watchdog limit in the same cycle.
        if (bus.done[idx_q]) begin
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = rr_next;
          state_d  = S_GAP;
        end else if (wdog_q == CW'(MAX_GRANT - 1)) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          rr_ptr_d  = rr_next;
          state_d   = S_GAP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output path: coordinates hold their last value while no grant is active.
  always_comb begin
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    plot_out_d   = plot_sel;
    if (grant_q != '0) begin
      x_out_d      = x_sel;
      y_out_d      = y_sel;
      colour_out_d = colour_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      idx_q        <= '0;
      rr_ptr_q     <= '0;
      wdog_q       <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      rr_ptr_q     <= rr_ptr_d;
      wdog_q       <= wdog_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
      plot_out_q   <= plot_out_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;
  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_out_q;
  assign bus.plot_out   = plot_out_q;

endmodule
